// File: rtl/sum_latch_uart_tx.sv
// Multi-channel operand latch + adder feeding a UART transmitter (8N1, or 8E1 when UART_PARITY_EN is defined).
// The result is sent LSB byte first as NBYTES back-to-back frames.
module sum_latch_uart_tx #(
    parameter  int DATA_W       = 5,
    parameter  int NUM_CH       = 2,
    parameter  int CLKS_PER_BIT = 868,
    localparam int SUM_W        = DATA_W + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] save_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              uart_tx_en,
    output logic              uart_txd,
    output logic              uart_tx_busy,
    output logic [SUM_W-1:0]  sum_out
);

    // state    | meaning
    // IDLE     | line high, waiting for pending result and uart_tx_en
    // START    | start bit (txd=0)
    // DATA     | 8 data bits, LSB first
    // PARITY   | even parity bit (UART_PARITY_EN builds only)
    // STOP     | stop bit (txd=1), then next byte or IDLE

    localparam int NBYTES = (SUM_W + 7) / 8;
    localparam int SHW    = NBYTES * 8;
    localparam int TW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [NUM_CH-1:0] save_s1, save_s2, save_s3;
    logic [DATA_W-1:0] data_s1, data_s2;
    logic [NUM_CH-1:0] save_pulse;
    logic [DATA_W-1:0] op [NUM_CH];
    logic [NUM_CH-1:0] valid;
    logic              round_done;
    logic [SUM_W-1:0]  sum_c;
    logic [SUM_W-1:0]  pend_buf;
    logic              pending;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_cnt;
    logic [BW-1:0]     byte_idx;
    logic [SHW-1:0]    shreg;
    logic              take;
    logic              bit_end;
    logic              last_byte;
    logic              txd_c;
`ifdef UART_PARITY_EN
    logic              parity;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            save_s1 <= '1;
            save_s2 <= '1;
            save_s3 <= '1;
            data_s1 <= '1;
            data_s2 <= '1;
        end else begin
            save_s1 <= save_n;
            save_s2 <= save_s1;
            save_s3 <= save_s2;
            data_s1 <= data_input;
            data_s2 <= data_s1;
        end
    end

    assign save_pulse = save_s3 & ~save_s2;
    assign round_done = &valid;

    // Saves arriving in the same cycle a round completes count toward the next round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) op[i] <= '0;
            valid <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (save_pulse[i]) op[i] <= data_s2;
            end
            valid <= (round_done ? '0 : valid) | save_pulse;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_CH; i++) sum_c = sum_c + SUM_W'(op[i]);
    end

    // A new result wins over a simultaneous take, so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_out  <= '0;
            pend_buf <= '0;
            pending  <= 1'b0;
        end else if (round_done) begin
            sum_out  <= sum_c;
            pend_buf <= sum_c;
            pending  <= 1'b1;
        end else if (take) begin
            pending  <= 1'b0;
        end
    end

    assign bit_end   = (timer == '0);
    assign last_byte = (32'(byte_idx) == NBYTES - 1);

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        txd_c     = 1'b1;
        unique case (state)
            IDLE: begin
                if (pending && uart_tx_en) begin
                    take      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                txd_c = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                txd_c = shreg[0];
`ifdef UART_PARITY_EN
                if (bit_end && bit_cnt == 3'd7) state_nxt = PARITY;
`else
                if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                txd_c = parity;
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_nxt = last_byte ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
`ifdef UART_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (take || (state != IDLE && bit_end))
                timer <= RELOAD;
            else if (state != IDLE)
                timer <= timer - TW'(1);
            if (take) begin
                shreg    <= SHW'(pend_buf);
                byte_idx <= '0;
            end
            if (state == START) begin
                bit_cnt <= '0;
`ifdef UART_PARITY_EN
                parity  <= 1'b0;
`endif
            end
            // After 8 shifts the next byte sits at shreg[7:0].
            if (state == DATA && bit_end) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
                parity  <= parity ^ shreg[0];
`endif
            end
            if (state == STOP && bit_end && !last_byte)
                byte_idx <= byte_idx + BW'(1);
        end
    end

    assign uart_txd     = txd_c;
    assign uart_tx_busy = (state != IDLE);

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Bench for sum_latch_uart_tx: a 2x5-bit instance (single frame) and a 4x8-bit instance (two frames).
// Expected bytes are queued when saves are driven and popped by a UART frame monitor.
module tb_sum_latch_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n, en_a, en_b;
    logic [1:0] save_a;
    logic [4:0] data_a;
    logic       txd_a, busy_a;
    logic [5:0] sum_a;
    logic [3:0] save_b;
    logic [7:0] data_b;
    logic       txd_b, busy_b;
    logic [9:0] sum_b;

    sum_latch_uart_tx #(.DATA_W(5), .NUM_CH(2), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .save_n(save_a), .data_input(data_a),
        .uart_tx_en(en_a), .uart_txd(txd_a), .uart_tx_busy(busy_a), .sum_out(sum_a));

    sum_latch_uart_tx #(.DATA_W(8), .NUM_CH(4), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .save_n(save_b), .data_input(data_b),
        .uart_tx_en(en_b), .uart_txd(txd_b), .uart_tx_busy(busy_b), .sum_out(sum_b));

    int n_checks = 0;
    int n_err = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [1:0] mon_off = 2'b00;

    typedef struct { int a; int b; int s; } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Samples each bit cell mid-way and checks framing, data and busy length.
    task automatic mon(input int sel, input int nb);
        logic cells [0:63];
        int cnt;
        int base;
        logic [7:0] d;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if ((sel == 0 ? busy_a : busy_b) && !mon_off[sel]) begin
                cnt = 0;
                while ((sel == 0 ? busy_a : busy_b) && cnt < 400) begin
                    if (cnt % CPB == CPB / 2 && cnt / CPB < 64)
                        cells[cnt / CPB] = (sel == 0) ? txd_a : txd_b;
                    cnt++;
                    @(negedge clk);
                end
                if (!mon_off[sel]) begin
                    check("busy_len", cnt, nb * F * CPB);
                    for (int f = 0; f < nb; f++) begin
                        base = f * F;
                        for (int k = 0; k < 8; k++) d[k] = cells[base + 1 + k];
                        check("start_bit", int'(cells[base]), 0);
                        check("stop_bit", int'(cells[base + F - 1]), 1);
`ifdef UART_PARITY_EN
                        check("parity_bit", int'(cells[base + 9]), int'(^d));
`endif
                        if ((sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
                            check("unexpected_frame", int'(d), -1);
                        end else begin
                            e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
                            check("frame_data", int'(d), int'(e));
                        end
                    end
                end
            end
        end
    endtask

    initial mon(0, 1);
    initial mon(1, 2);

    task automatic save(input int sel, input logic [3:0] mask, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin
            data_a = d[4:0];
            save_a = ~mask[1:0];
        end else begin
            data_b = d;
            save_b = ~mask;
        end
        repeat (3) @(negedge clk);
        save_a = '1;
        save_b = '1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int sel);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sel == 0 ? (q_a.size() == 0 && !busy_a) : (q_b.size() == 0 && !busy_b)) break;
        end
        check("drain_done", int'(i < 3000), 1);
    endtask

    initial begin
        int seen;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1;
        save_a = '1; save_b = '1;
        data_a = '0; data_b = '0;
        vecs[0] = '{0, 0, 0};
        vecs[1] = '{31, 31, 62};
        vecs[2] = '{1, 0, 1};
        vecs[3] = '{16, 15, 31};
        vecs[4] = '{5, 26, 31};

        repeat (3) @(negedge clk);
        check("rst_txd_a", int'(txd_a), 1);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_sum_a", int'(sum_a), 0);
        check("rst_txd_b", int'(txd_b), 1);
        check("rst_sum_b", int'(sum_b), 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic round 17 + 22 with exact latency checks.
        save(0, 4'b0001, 8'd17);
        q_a.push_back(8'd39);
        @(negedge clk);
        data_a = 5'd22;
        save_a = 2'b01;
        repeat (3) @(negedge clk);
        check("sum_before_lat", int'(sum_a), 0);
        check("busy_before", int'(busy_a), 0);
        save_a = '1;
        @(negedge clk);
        check("sum_lat", int'(sum_a), 39);
        check("busy_wait_start", int'(busy_a), 0);
        @(negedge clk);
        check("busy_rise", int'(busy_a), 1);
        check("txd_start", int'(txd_a), 0);
        wait_idle(0);

        for (int i = 0; i < 5; i++) begin
            save(0, 4'b0001, 8'(vecs[i].a));
            q_a.push_back(8'(vecs[i].s));
            save(0, 4'b0010, 8'(vecs[i].b));
            wait_idle(0);
            check("vec_sum", int'(sum_a), vecs[i].s);
        end

        // Gating with overwrite of the pending result.
        en_a = 1'b0;
        save(0, 4'b0001, 8'd3);
        save(0, 4'b0010, 8'd4);
        repeat (10) @(negedge clk);
        check("gate_busy", int'(busy_a), 0);
        save(0, 4'b0001, 8'd10);
        save(0, 4'b0010, 8'd5);
        repeat (10) @(negedge clk);
        check("gate_sum", int'(sum_a), 15);
        check("gate_busy2", int'(busy_a), 0);
        check("gate_txd", int'(txd_a), 1);
        q_a.push_back(8'd15);
        en_a = 1'b1;
        wait_idle(0);
        repeat (100) @(negedge clk);
        check("single_frame", q_a.size(), 0);

        // Saves during an active frame, both channels at once.
        q_a.push_back(8'd25);
        save(0, 4'b0001, 8'd12);
        save(0, 4'b0010, 8'd13);
        check("overlap_busy", int'(busy_a), 1);
        q_a.push_back(8'd18);
        save(0, 4'b0011, 8'd9);
        check("overlap_sum", int'(sum_a), 18);
        check("overlap_busy_mid", int'(busy_a), 1);
        wait_idle(0);

        // Multi-byte result on the 4x8 instance.
        q_b.push_back(8'hFC);
        q_b.push_back(8'h03);
        save(1, 4'b0001, 8'd255);
        save(1, 4'b0010, 8'd255);
        save(1, 4'b0100, 8'd255);
        save(1, 4'b1000, 8'd255);
        wait_idle(1);
        check("multi_sum", int'(sum_b), 1020);

        // Asynchronous reset in the middle of a frame.
        save(1, 4'b1111, 8'd1);
        repeat (15) @(negedge clk);
        check("pre_reset_busy", int'(busy_b), 1);
        mon_off[1] = 1'b1;
        #2 rst_b_n = 1'b0;
        #1;
        check("reset_txd", int'(txd_b), 1);
        check("reset_busy", int'(busy_b), 0);
        check("reset_sum", int'(sum_b), 0);
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (5) @(negedge clk);
        mon_off[1] = 1'b0;

        seen = 0;
        save(1, 4'b0001, 8'd5);
        save(1, 4'b0010, 8'd5);
        save(1, 4'b0100, 8'd5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_b) seen = 1;
        end
        check("no_frame_partial", seen, 0);
        q_b.push_back(8'd20);
        q_b.push_back(8'd0);
        save(1, 4'b1000, 8'd5);
        wait_idle(1);
        check("post_reset_sum", int'(sum_b), 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sum_latch_uart_tx.md
# sum_latch_uart_tx

Parametrised multi-channel operand latch, adder and UART transmitter; the next-generation replacement for the two-operand latch/sum/UART core that sits behind the Tiny Tapeout top-level wrapper. NUM_CH operands of DATA_W bits are captured from a shared data bus on active-low save strobes. Once every channel holds a fresh operand, their sum is transmitted LSB-byte-first as one or more 8N1 (optionally 8E1) UART frames.

## Interface
- DATA_W, 5: operand width, 1..16.
- NUM_CH, 2: channel count, 2..8.
- CLKS_PER_BIT, 868: clock cycles per UART bit, ≥ 2.
- SUM_W, derived = DATA_W + $clog2(NUM_CH): sum width, not overridable.
- NBYTES, derived = ceil(SUM_W/8): frames per result.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- save_n  in  NUM_CH  per-channel save strobes, active-low, asynchronous to clk.
- data_input  in  DATA_W  shared operand bus, sampled on a save event.
- uart_tx_en  in  1  transmit permission; a pending result waits while low.
- uart_txd  out  1  UART serial line; idle high.
- uart_tx_busy  out  1  high from the first start bit through the last stop bit of a result.
- sum_out  out  SUM_W  last result computed, held until the next result.

## Operation
- Each save_n bit passes through a 2-flop synchroniser and then a falling-edge detector, giving a one-cycle save pulse per channel.
- On a save pulse for channel i:
  - the synchronised data_input is written to op[i];
  - valid[i] is set.
  - A repeat save before the round completes overwrites op[i].
  - Simultaneous pulses on several channels latch the same data into all of them.
- data_input passes through a 2-flop synchroniser aligned with save_n.
- When valid is all ones:
  - sum = zero-extended sum of all op[i], SUM_W bits, which cannot overflow;
  - sum is registered into sum_out and into a pending buffer, with pending=1;
  - valid is cleared in the same cycle.
- Pending buffer rules:
  - one entry deep;
  - a new result while pending=1 overwrites the buffer (last result wins);
  - sum_out always updates.
- Tx FSM, states IDLE → START → DATA → [PARITY] → STOP → (next byte START | IDLE):
  - IDLE: if pending && uart_tx_en, load the buffer into a zero-padded NBYTES×8 shift register, clear pending, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if the byte index < NBYTES-1, go to START for the next byte with no idle gap; otherwise go to IDLE.
- uart_tx_en falling mid-result does not abort the transfer; it is checked only in IDLE.
- Saves during transmission are accepted and accumulate toward the next round.

## Timing
- Reset values:
  - uart_txd=1, uart_tx_busy=0, sum_out=0;
  - valid=0, pending=0, all op[i]=0;
  - FSM in IDLE, synchronisers at 1.
- Reset mid-frame forces txd=1 and busy=0 immediately (asynchronously).
- Save latency: op[i] and valid[i] update on the 3rd rising edge after save_n falls, given setup at edge 1.
- Sum latency: sum_out and pending update 1 cycle after valid becomes all ones.
- Tx start: with uart_tx_en=1, the FSM leaves IDLE 1 cycle after pending sets. txd falls and busy rises in that cycle.
- Result duration: busy is high for exactly NBYTES × F × CLKS_PER_BIT cycles, where F=10 (F=11 with parity).
- busy drops in the cycle after the last stop bit ends.
- The bit timer reloads at every bit boundary, with no cumulative drift.

## Configuration
- UART_PARITY_EN defined:
  - a PARITY state follows DATA;
  - txd carries even parity, the XOR of the 8 data bits, for CLKS_PER_BIT cycles;
  - the frame is 8E1, 11 bits.
- UART_PARITY_EN undefined: PARITY state and logic are absent; the frame is 8N1, 10 bits.

## Test plan
- Reset: hold reset_n low mid-frame → txd=1, busy=0, sum_out=0 within the same cycle. After release, no frame is sent until a full round of saves completes.
- Basic round (DATA_W=5, NUM_CH=2, CLKS_PER_BIT=4): save ch0 with 17, then ch1 with 22 → sum_out=39. One frame on txd: 0,1,1,1,0,0,1,0,0,1, each bit 4 cycles. busy is high for 40 cycles.
- Multi-byte (DATA_W=8, NUM_CH=4): save all four channels with 255 → sum_out=1020. Frames carry 0xFC then 0x03, back to back. busy is high for 2×10×CLKS_PER_BIT cycles.
- Gating and overwrite: hold uart_tx_en=0 and complete two rounds, 3+4 then 10+5 → sum_out=15, txd stays idle. Raise uart_tx_en → a single frame carrying 0x0F.
- Overlap and simultaneity: during an active frame, pulse both save_n bits together with data 9 → after the frame ends, a frame carrying 18 follows.
- Parity build (UART_PARITY_EN, sum 39): the parity bit is 0 and the frame is 11 bits. A sum of 0x01 gives a parity bit of 1.
